ballot_session_ctrl: RTL

//  Sequences one voter at a time into the vote-counter datapath.
//  - Officer arms a session; voter selects exactly one candidate, holds it stable, then confirms.
//  - Block then issues a single one-cycle one-hot cast strobe to the counter.
//  - Sits between the booth buttons (already synchronised) and the counter.
//  - Guarantees at most one vote per arm, with no multi-select and no double-count.

---
 rtl/ballot_session_ctrl.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/ballot_session_ctrl.sv
// rtl/ballot_session_ctrl.sv - one-voter-at-a-time ballot sequencer in front of the vote counter
//
// Purpose:
//   The officer arms a session. The voter then holds exactly one candidate
//   button stable for HOLD_CYCLES cycles and presses confirm. The block then
//   emits a single one-cycle one-hot cast strobe. It allows at most one vote
//   per arm, rejects multi-select, and never double-counts a held button.
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   poll_open      level, polling station open; dropping it aborts an open session
//   arm            officer pulse, admits the next voter (IDLE only)
//   sel            candidate buttons, level, 1 = pressed (already synchronised)
//   confirm        voter confirm button, level; acts on its rising edge
//   cast_valid     one-cycle vote strobe to the counter (registered)
//   cast_sel       one-hot candidate, valid with cast_valid, else 0 (registered)
//   ready          1 while waiting for the voter (ARMED/STABLE/SELECTED)
//   reject         one-cycle pulse, confirm edge with multi-hot sel (registered)
//   timeout        one-cycle pulse, session aborted by timer (registered)
//   voters_served  votes cast since reset, saturates at MAX_VOTERS (registered)
//   closed         ~poll_open | (voters_served == MAX_VOTERS)
//
// Build option:
//   BALLOT_TIMEOUT_EN - when defined, a session that stays open for
//   TIMEOUT_CYCLES cycles after arming is aborted and timeout pulses.
//   When undefined, there is no timer and timeout is tied to 0.

module ballot_session_ctrl #(
    parameter int NUM_CAND       = 3,
    parameter int HOLD_CYCLES    = 4,
    parameter int MAX_VOTERS     = 15,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            poll_open,
    input  logic                            arm,
    input  logic [NUM_CAND-1:0]             sel,
    input  logic                            confirm,
    output logic                            cast_valid,
    output logic [NUM_CAND-1:0]             cast_sel,
    output logic                            ready,
    output logic                            reject,
    output logic                            timeout,
    output logic [$clog2(MAX_VOTERS+1)-1:0] voters_served,
    output logic                            closed
);

    localparam int VW = $clog2(MAX_VOTERS + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [VW-1:0] VMAX     = VW'(MAX_VOTERS);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_STABLE,
        S_SELECTED,
        S_CAST,
        S_RELEASE
    } state_t;

    state_t              state, state_nxt;
    logic [NUM_CAND-1:0] cand_q, cand_nxt;
    logic [HW-1:0]       hold_cnt, hold_nxt;
    logic                confirm_q;
    logic                cast_nxt, reject_nxt, timeout_nxt;

    logic confirm_edge, sel_onehot, sel_none, sel_multi, full, active;

    assign confirm_edge = confirm & ~confirm_q;
    assign sel_onehot   = $onehot(sel);
    assign sel_none     = (sel == '0);
    assign sel_multi    = ~sel_onehot & ~sel_none;
    assign full         = (voters_served == VMAX);
    assign active       = (state == S_ARMED) || (state == S_STABLE) || (state == S_SELECTED);

    assign ready  = active;
    assign closed = ~poll_open | full;

`ifdef BALLOT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] timer;
    logic          timer_expire;

    // Timer sits at 0 in IDLE, so it is effectively cleared on IDLE->ARMED,
    // and freezes in CAST/RELEASE where it no longer matters.
    always_ff @(posedge clk) begin
        if (rst || state == S_IDLE) begin
            timer <= '0;
        end else if (active) begin
            timer <= timer + TW'(1);
        end
    end

    assign timer_expire = active && (timer == TLAST);
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_nxt   = state;
        cand_nxt    = cand_q;
        hold_nxt    = hold_cnt;
        cast_nxt    = 1'b0;
        reject_nxt  = 1'b0;
        timeout_nxt = 1'b0;

        case (state)
            S_IDLE: begin
                hold_nxt = '0;
                if (arm && poll_open && !full) begin
                    state_nxt = S_ARMED;
                end
            end
            S_ARMED: begin
                if (sel_onehot) begin
                    cand_nxt  = sel;
                    hold_nxt  = HW'(1);
                    state_nxt = (HOLD_CYCLES == 1) ? S_SELECTED : S_STABLE;
                end
            end
            S_STABLE: begin
                if (sel == cand_q) begin
                    hold_nxt = hold_cnt + HW'(1);
                    if (hold_cnt >= HOLD_MAX - HW'(1)) begin
                        state_nxt = S_SELECTED;
                    end
                end else begin
                    hold_nxt  = '0;
                    state_nxt = S_ARMED;
                end
            end
            S_SELECTED: begin
                // Releasing the button is allowed; cand_q keeps the choice.
                if (confirm_edge && (sel_none || sel == cand_q)) begin
                    cast_nxt  = 1'b1;
                    state_nxt = S_CAST;
                end else if (confirm_edge && sel_multi) begin
                    reject_nxt = 1'b1;
                    hold_nxt   = '0;
                    state_nxt  = S_ARMED;
                end else if (sel_onehot && sel != cand_q) begin
                    // A new candidate must earn its own full hold period.
                    cand_nxt  = sel;
                    hold_nxt  = HW'(1);
                    state_nxt = (HOLD_CYCLES == 1) ? S_SELECTED : S_STABLE;
                end
            end
            S_CAST: begin
                state_nxt = S_RELEASE;
            end
            S_RELEASE: begin
                // Both inputs must drop before the next arm can be accepted,
                // so a held button or confirm cannot produce a second vote.
                if (sel_none && !confirm) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // The abort paths override anything decided above, including a
        // confirm edge in the same cycle.
        if (active && !poll_open) begin
            state_nxt  = S_IDLE;
            hold_nxt   = '0;
            cast_nxt   = 1'b0;
            reject_nxt = 1'b0;
        end
`ifdef BALLOT_TIMEOUT_EN
        else if (timer_expire) begin
            state_nxt   = S_IDLE;
            hold_nxt    = '0;
            cast_nxt    = 1'b0;
            reject_nxt  = 1'b0;
            timeout_nxt = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            cand_q        <= '0;
            hold_cnt      <= '0;
            confirm_q     <= 1'b0;
            cast_valid    <= 1'b0;
            cast_sel      <= '0;
            reject        <= 1'b0;
            timeout       <= 1'b0;
            voters_served <= '0;
        end else begin
            state      <= state_nxt;
            cand_q     <= cand_nxt;
            hold_cnt   <= hold_nxt;
            confirm_q  <= confirm;
            cast_valid <= cast_nxt;
            cast_sel   <= cast_nxt ? cand_q : '0;
            reject     <= reject_nxt;
            timeout    <= timeout_nxt;
            if (cast_nxt && !full) begin
                voters_served <= voters_served + VW'(1);
            end
        end
    end

endmodule
